lbuf_wr_ctrl: RTL

// Write-side controller for the NUM_LINE_BUFFERS-deep circular line buffer feeding the output sync generator.

---
 rtl/lbuf_wr_ctrl_if.sv | 29 ++
 rtl/lbuf_wr_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/lbuf_wr_ctrl_if.sv
// Source-side and buffer-side signals of the line-buffer write controller.
interface lbuf_wr_ctrl_if #(parameter int DATA_W = 12);
  logic              HSYNC_in;
  logic              VSYNC_in;
  logic              DE_in;
  logic [DATA_W-1:0] data_in;
  logic [8:0]        h_active;
  logic [8:0]        v_start;
  logic [8:0]        v_active;
  logic [5:0]        rd_line;
  logic              clr_status;
  logic              wr_en;
  logic [5:0]        wr_line;
  logic [8:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_start;
  logic              line_done;
  logic [5:0]        lines_ahead;
  logic              overrun;

  modport master (
    output HSYNC_in, VSYNC_in, DE_in, data_in, h_active, v_start, v_active, rd_line, clr_status,
    input  wr_en, wr_line, wr_addr, wr_data, frame_start, line_done, lines_ahead, overrun
  );
  modport slave (
    input  HSYNC_in, VSYNC_in, DE_in, data_in, h_active, v_start, v_active, rd_line, clr_status,
    output wr_en, wr_line, wr_addr, wr_data, frame_start, line_done, lines_ahead, overrun
  );
endinterface

// File: rtl/lbuf_wr_ctrl.sv
// Write-side controller of the circular line buffer: window capture, line/pixel
// addressing and overrun detection against the output read line.
module lbuf_wr_ctrl #(
  parameter int NUM_LINE_BUFFERS = 40,
  parameter int DATA_W           = 12
) (
  input  logic          PCLK,
  input  logic          reset_n,
  lbuf_wr_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, VBLANK, LINE_WAIT, CAPTURE, LINE_END} state_t;

  localparam logic [5:0] LAST_LINE = 6'(NUM_LINE_BUFFERS - 1);
  localparam logic [6:0] NLB7      = 7'(NUM_LINE_BUFFERS);

  state_t            r_state;
  logic              r_prev_hs, r_prev_vs, r_prev_de;
  logic [8:0]        r_h_act, r_v_start, r_v_act;
  logic [8:0]        r_hs_cnt, r_line_cnt, r_pix_cnt;
  logic              r_wr_en, r_frame_start, r_line_done, r_overrun;
  logic [5:0]        r_wr_line, r_lines_ahead;
  logic [8:0]        r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic       w_vs_fall, w_hs_fall, w_de_rise, w_pix_last, w_pix_full, w_collide;
  logic [5:0] w_next_line, w_upd_line, w_ahead;
  logic [6:0] w_diff;

  assign w_vs_fall   = r_prev_vs & ~bus.VSYNC_in;
  assign w_hs_fall   = r_prev_hs & ~bus.HSYNC_in;
  assign w_de_rise   = bus.DE_in & ~r_prev_de;
  assign w_pix_last  = ({1'b0, r_pix_cnt} + 10'd1) == {1'b0, r_h_act};
  assign w_pix_full  = r_pix_cnt >= r_h_act;
  assign w_next_line = (r_wr_line == LAST_LINE) ? 6'd0 : r_wr_line + 6'd1;
  assign w_collide   = (r_state == LINE_END) && !w_vs_fall && (w_next_line == bus.rd_line);
  assign w_upd_line  = w_collide ? r_wr_line : w_next_line;
  assign w_diff      = {1'b0, w_upd_line} - {1'b0, bus.rd_line};
  assign w_ahead     = (w_upd_line < bus.rd_line) ? 6'(w_diff + NLB7) : w_diff[5:0];

  assign bus.wr_en       = r_wr_en;
  assign bus.wr_line     = r_wr_line;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.frame_start = r_frame_start;
  assign bus.line_done   = r_line_done;
  assign bus.lines_ahead = r_lines_ahead;
  assign bus.overrun     = r_overrun;

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_prev_hs     <= 1'b1;
      r_prev_vs     <= 1'b1;
      r_prev_de     <= 1'b0;
      r_h_act       <= '0;
      r_v_start     <= '0;
      r_v_act       <= '0;
      r_hs_cnt      <= '0;
      r_line_cnt    <= '0;
      r_pix_cnt     <= '0;
      r_wr_en       <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      r_overrun     <= 1'b0;
      r_wr_line     <= '0;
      r_lines_ahead <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
    end else begin
      r_prev_hs     <= bus.HSYNC_in;
      r_prev_vs     <= bus.VSYNC_in;
      r_prev_de     <= bus.DE_in;
      r_wr_en       <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      if (w_collide)           r_overrun <= 1'b1;
      else if (bus.clr_status) r_overrun <= 1'b0;

      if (w_vs_fall) begin
        r_h_act       <= bus.h_active;
        r_v_start     <= bus.v_start;
        r_v_act       <= bus.v_active;
        r_wr_line     <= '0;
        r_line_cnt    <= '0;
        r_hs_cnt      <= '0;
        r_frame_start <= 1'b1;
        r_state       <= VBLANK;
      end else begin
        case (r_state)
          IDLE: ;
          VBLANK: begin
            if (r_v_start == 9'd0) r_state <= LINE_WAIT;
            else if (w_hs_fall) begin
              r_hs_cnt <= r_hs_cnt + 9'd1;
              if (r_hs_cnt + 9'd1 == r_v_start) r_state <= LINE_WAIT;
            end
          end
          // A line starts on a DE rising edge so the tail of an over-long
          // DE burst cannot open the next line.
          LINE_WAIT: begin
            if (w_de_rise) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= '0;
              r_wr_data <= bus.data_in;
              r_pix_cnt <= 9'd1;
              r_state   <= (r_h_act <= 9'd1) ? LINE_END : CAPTURE;
            end
          end
          CAPTURE: begin
            if (w_hs_fall || !bus.DE_in || w_pix_full) r_state <= LINE_END;
            else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_pix_cnt;
              r_wr_data <= bus.data_in;
              r_pix_cnt <= r_pix_cnt + 9'd1;
              if (w_pix_last) r_state <= LINE_END;
            end
          end
          LINE_END: begin
            r_line_done   <= 1'b1;
            r_line_cnt    <= r_line_cnt + 9'd1;
            r_wr_line     <= w_upd_line;
            r_lines_ahead <= w_ahead;
            r_state       <= (r_line_cnt + 9'd1 == r_v_act) ? IDLE : LINE_WAIT;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
